test_monitor: RTL
=================

Name: test_monitor

Overview:
- Parametrised, synthesizable end-of-test controller sitting between the clock/reset source and the test harness.
- Sequences a held DUT reset, then watches NUM_CH per-channel success/failure/progress lines.
- Enforces a runtime cycle budget and a per-channel stall watchdog.
- Latches a single terminal verdict (pass/fail + reason + channel) for the bench or a UVM objection to consume.

Parameters:
- NUM_CH, 4, number of monitored channels (1..32)
- CYCLE_W, 64, width of cycle counter and max_cycles
- RESET_CYCLES, 16, cycles dut_reset is held after reset deasserts (>=1)
- STALL_LIMIT, 100000, max cycles an enabled, not-yet-done channel may go without progress; 0 disables
- CH_IDX_W, $clog2(NUM_CH) min 1, width of fail_ch

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- max_cycles  in  CYCLE_W  runtime cycle budget counted from RUN entry; 0 = no timeout; sampled every cycle
- ch_enable  in  NUM_CH  channel mask; sampled once on RESET_HOLD->RUN and held internally
- ch_success  in  NUM_CH  per-channel success pulse or level
- ch_failure  in  NUM_CH  per-channel failure pulse or level
- ch_progress  in  NUM_CH  per-channel heartbeat pulse
- dut_reset  out  1  reset to harness
- running  out  1  high in RUN
- done  out  1  high in PASS or FAIL (sticky)
- pass  out  1  high in PASS
- fail  out  1  high in FAIL
- reason  out  2  0 none, 1 channel failure, 2 timeout, 3 stall
- fail_ch  out  CH_IDX_W  offending channel (reasons 1 and 3), else 0
- cycle_count  out  CYCLE_W  cycles spent in RUN, saturating

Behaviour:
- Async reset values:
  - state = RESET_HOLD, dut_reset = 1, all other outputs 0
  - hold counter = 0, done mask = 0, stall counters = 0
- RESET_HOLD:
  - hold counter increments each clock.
  - On the clock where the counter reaches RESET_CYCLES-1: go to RUN, latch ch_enable, clear cycle_count.
  - dut_reset = 1 throughout; drops the cycle RUN is entered, i.e. exactly RESET_CYCLES clocks after reset deasserts.
- RUN:
  - cycle_count increments by 1 each cycle, saturating at all-ones.
  - Done mask bit i sets sticky on ch_success[i] & en[i].
  - Stall counter i:
    - clears on ch_progress[i] or when done[i] is set;
    - otherwise increments, saturating at STALL_LIMIT;
    - stall fires when it reaches STALL_LIMIT and en[i] & !done[i].
  - Timeout fires when max_cycles != 0 and cycle_count >= max_cycles (evaluated pre-increment).
- Failure causes are evaluated in the same cycle, in priority order:
  - 1. ch_failure & en (lowest index wins)
  - 2. timeout
  - 3. stall (lowest index wins)
- Any failure cause -> FAIL next cycle, latching reason and fail_ch. Failure beats success in the same cycle.
- Success: if no failure cause and (done_mask | ch_success&en) covers en -> PASS next cycle.
- ch_enable latched as 0: PASS on the first RUN cycle (vacuous).
- PASS and FAIL are absorbing. Only reset leaves them.
  - In both, dut_reset = 0, cycle_count frozen, channel inputs ignored.
- Reset asserted mid-run: returns immediately to RESET_HOLD and discards the verdict.
- Inputs from unenabled channels are ignored entirely.
- All outputs registered; verdict visible 1 cycle after the causing input.

Optional Feature:
- Macro: TEST_MONITOR_STAMP_EN
- With the macro defined:
  - Extra output ch_done_cycle, NUM_CH*CYCLE_W bits.
  - Slice i captures cycle_count on the cycle done[i] first sets; reset value 0.
  - Slices for channels that never succeed stay 0.
- Without the macro: port and registers are absent; behaviour otherwise identical.

Decomposition:
- Package test_monitor_pkg:
  - state enum {RESET_HOLD, RUN, PASS, FAIL}
  - reason enum {R_NONE=0, R_CHFAIL=1, R_TIMEOUT=2, R_STALL=3}
  - lowest-set-bit index function
- One natural sub-module: test_monitor_chan, instantiated NUM_CH times.
  - Holds the per-channel done bit, stall counter and (optional) stamp.
  - Outputs done_i and stall_i.

Test Plan:
- NUM_CH=4, en=4'b1111, RESET_CYCLES=16 -> dut_reset high for exactly 16 clocks after reset release; running rises the same edge dut_reset falls.
- Channels succeed at RUN cycles 10, 20, 30, 40, progress every 5 -> pass=1 at cycle 41, reason=0; with STAMP_EN ch_done_cycle = {40,30,20,10}.
- max_cycles=50, only ch0 succeeds -> fail=1, reason=2 one cycle after cycle_count reaches 50, fail_ch=0.
- ch_failure=4'b1010 and ch_success covering all in the same cycle -> fail, reason=1, fail_ch=1.
- STALL_LIMIT=8, ch2 never pulses progress, en=4'b0100 -> fail, reason=3, fail_ch=2 after 8 stalled cycles; with en=4'b0000 -> pass on first RUN cycle.
- Reset asserted 3 cycles after FAIL -> all outputs 0, dut_reset=1 asynchronously; full sequence repeats cleanly.

Source files
------------

// File: rtl/test_monitor_pkg.sv
// test_monitor_pkg: state/reason encodings and a lowest-set-bit helper for test_monitor
package test_monitor_pkg;
    typedef enum logic [1:0] {RESET_HOLD, RUN, PASS, FAIL} state_t;
    typedef enum logic [1:0] {R_NONE = 2'd0, R_CHFAIL = 2'd1, R_TIMEOUT = 2'd2, R_STALL = 2'd3} reason_t;
    function automatic logic [4:0] lsb_idx(input logic [31:0] v);
        lsb_idx = '0;
        for (int i = 31; i >= 0; i--)
            if (v[i]) lsb_idx = 5'(i);
    endfunction
endpackage

// File: rtl/test_monitor_chan.sv
// test_monitor_chan: per-channel sticky done flag, stall watchdog and optional done stamp
module test_monitor_chan
    import test_monitor_pkg::*;
#(
    parameter int CYCLE_W     = 64,
    parameter int STALL_LIMIT = 100000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run,
    input  logic               en,
    input  logic               success,
    input  logic               progress,
    input  logic [CYCLE_W-1:0] cycle_count,
    output logic               done_i,
    output logic               stall_i
`ifdef TEST_MONITOR_STAMP_EN
    ,
    output logic [CYCLE_W-1:0] stamp
`endif
);
    localparam int SW = STALL_LIMIT > 0 ? $clog2(STALL_LIMIT + 1) : 1;
    logic [SW-1:0] stall_cnt;
    logic hit;
    assign hit = run & en & success;
    assign stall_i = (STALL_LIMIT != 0) && stall_cnt == SW'(STALL_LIMIT) && en && !done_i;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            done_i    <= 1'b0;
            stall_cnt <= '0;
        end else if (run) begin
            if (hit) done_i <= 1'b1;
            stall_cnt <= (progress || done_i) ? '0 :
                         (stall_cnt == SW'(STALL_LIMIT)) ? stall_cnt : stall_cnt + 1'b1;
        end
    end
`ifdef TEST_MONITOR_STAMP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) stamp <= '0;
        else if (hit && !done_i) stamp <= cycle_count;
    end
`endif
endmodule

// File: rtl/test_monitor.sv
// test_monitor: end-of-test controller (reset hold, cycle budget, stall watchdog, latched verdict)
// Optional TEST_MONITOR_STAMP_EN adds ch_done_cycle, the cycle each channel first succeeded.
module test_monitor
    import test_monitor_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int CYCLE_W      = 64,
    parameter int RESET_CYCLES = 16,
    parameter int STALL_LIMIT  = 100000,
    parameter int CH_IDX_W     = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CYCLE_W-1:0]  max_cycles,
    input  logic [NUM_CH-1:0]   ch_enable,
    input  logic [NUM_CH-1:0]   ch_success,
    input  logic [NUM_CH-1:0]   ch_failure,
    input  logic [NUM_CH-1:0]   ch_progress,
    output logic                dut_reset,
    output logic                running,
    output logic                done,
    output logic                pass,
    output logic                fail,
    output logic [1:0]          reason,
    output logic [CH_IDX_W-1:0] fail_ch,
    output logic [CYCLE_W-1:0]  cycle_count
`ifdef TEST_MONITOR_STAMP_EN
    ,
    output logic [NUM_CH*CYCLE_W-1:0] ch_done_cycle
`endif
);
    localparam int HW = RESET_CYCLES > 1 ? $clog2(RESET_CYCLES) : 1;
    state_t state, nxt;
    reason_t why;
    logic [HW-1:0] hold_cnt;
    logic [NUM_CH-1:0] en, done_m, stall_m, fail_m, cover_m;
    logic timeout;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        test_monitor_chan #(.CYCLE_W(CYCLE_W), .STALL_LIMIT(STALL_LIMIT)) u_ch (
            .clock      (clock),
            .reset      (reset),
            .run        (state == RUN),
            .en         (en[i]),
            .success    (ch_success[i]),
            .progress   (ch_progress[i]),
            .cycle_count(cycle_count),
            .done_i     (done_m[i]),
            .stall_i    (stall_m[i])
`ifdef TEST_MONITOR_STAMP_EN
            ,
            .stamp      (ch_done_cycle[i*CYCLE_W +: CYCLE_W])
`endif
        );
    end
    always_comb begin
        fail_m  = ch_failure & en;
        cover_m = done_m | (ch_success & en);
        timeout = max_cycles != '0 && cycle_count >= max_cycles;
        nxt     = state;
        why     = R_NONE;
        if (state == RESET_HOLD && hold_cnt == HW'(RESET_CYCLES - 1)) nxt = RUN;
        else if (state == RUN) begin
            // failure causes outrank success, and among themselves in this order
            if (|fail_m) begin
                nxt = FAIL;
                why = R_CHFAIL;
            end else if (timeout) begin
                nxt = FAIL;
                why = R_TIMEOUT;
            end else if (|stall_m) begin
                nxt = FAIL;
                why = R_STALL;
            end else if (cover_m == en) nxt = PASS;
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RESET_HOLD;
            hold_cnt    <= '0;
            en          <= '0;
            dut_reset   <= 1'b1;
            running     <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            reason      <= R_NONE;
            fail_ch     <= '0;
            cycle_count <= '0;
        end else begin
            state     <= nxt;
            dut_reset <= nxt == RESET_HOLD;
            running   <= nxt == RUN;
            done      <= nxt == PASS || nxt == FAIL;
            pass      <= nxt == PASS;
            fail      <= nxt == FAIL;
            if (state == RESET_HOLD) hold_cnt <= hold_cnt + 1'b1;
            if (state == RESET_HOLD && nxt == RUN) begin
                en          <= ch_enable;
                cycle_count <= '0;
            end
            if (state == RUN) begin
                if (!(&cycle_count)) cycle_count <= cycle_count + 1'b1;
                if (nxt == FAIL) begin
                    reason  <= why;
                    fail_ch <= why == R_CHFAIL ? CH_IDX_W'(lsb_idx(32'(fail_m))) :
                               why == R_STALL  ? CH_IDX_W'(lsb_idx(32'(stall_m))) : '0;
                end
            end
        end
    end
endmodule
